alloc_rsp_merger: RTL

Sits between the alloc response producers and the alloc response FIFO. There are two producers:
- the dispatcher's early-reject path (source A: zero-size or oversize requests);
- the FDT allocation-result path (source B).

Both may write in the same cycle. The block stages these writes in a small 2-write/1-read queue, serialises them into the single write port of the alloc rsp FIFO, and raises a combined almost_full back-pressure signal toward the producers.

---
 rtl/alloc_rsp_merger_pkg.sv | 29 ++
 rtl/alloc_rsp_merger_stage_fifo.sv | 62 ++++++
 rtl/alloc_rsp_merger.sv | 89 ++++++++
 3 files changed

// File: rtl/alloc_rsp_merger_pkg.sv
// Shared widths, fail-reason codes and entry layout for the alloc response merger.
// Entry layout is {id, page_idx, fail, fail_reason}, passed through unmodified.
package alloc_rsp_merger_pkg;

    localparam int REQ_ID_WIDTH       = 8;
    localparam int ALL_PAGE_IDX_WIDTH = 8;
    localparam int FAIL_REASON_WIDTH  = 3;
    localparam int RSP_ENTRY_WIDTH    = REQ_ID_WIDTH + ALL_PAGE_IDX_WIDTH + 1 + FAIL_REASON_WIDTH;

    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_NONE       = 3'd0;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_EQUAL_ZERO = 3'd1;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_OVERSIZE   = 3'd2;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_NO_SPACE   = 3'd3;

    typedef struct packed {
        logic [REQ_ID_WIDTH-1:0]       id;
        logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
        logic                          fail;
        logic [FAIL_REASON_WIDTH-1:0]  fail_reason;
    } rsp_entry_t;

    // Saturating add used by the drop counter; at most two drops per cycle.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/alloc_rsp_merger_stage_fifo.sv
// Two-write/one-read circular staging buffer. Port 0 has priority for free slots and
// lands in the lower slot; anything that does not fit is reported in drop.
module rsp_stage_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr0_en,
    input  logic [WIDTH-1:0]           wr0_data,
    input  logic                       wr1_en,
    input  logic [WIDTH-1:0]           wr1_data,
    input  logic                       rd_en,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head,
    output logic [1:0]                 drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr1;
    logic [CW-1:0]    free;
    logic             rd_eff;
    logic             acc0;
    logic             acc1;

    // A slot freed by this cycle's pop is reusable by this cycle's push.
    always_comb begin
        rd_eff = rd_en && (count != '0);
        free   = CW'(DEPTH) - count + CW'(rd_eff);
        acc0   = wr0_en && (free != '0);
        acc1   = wr1_en && (free > CW'(acc0));
        wptr1  = wptr + PW'(acc0);
        drop   = {wr1_en && !acc1, wr0_en && !acc0};
    end

    assign head = mem[rptr];

    // NOTE: storage carries no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (acc0) mem[wptr]  <= wr0_data;
        if (acc1) mem[wptr1] <= wr1_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(acc0) + PW'(acc1);
            rptr  <= rptr + PW'(rd_eff);
            count <= count + CW'(acc0) + CW'(acc1) - CW'(rd_eff);
        end
    end

endmodule

// File: rtl/alloc_rsp_merger.sv
// Merges the dispatcher early-reject (A) and FDT result (B) responses into the single
// alloc rsp FIFO write port, with back-pressure and sticky drop accounting.
module alloc_rsp_merger
    import alloc_rsp_merger_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_wr_en,
    input  logic [REQ_ID_WIDTH-1:0]       a_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] a_page_idx,
    input  logic                          a_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  a_fail_reason,
    input  logic                          b_wr_en,
    input  logic [REQ_ID_WIDTH-1:0]       b_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] b_page_idx,
    input  logic                          b_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  b_fail_reason,
    input  logic                          rsp_fifo_full,
    input  logic                          rsp_fifo_almost_full,
    output logic                          rsp_wr_en,
    output logic [REQ_ID_WIDTH-1:0]       rsp_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx,
    output logic                          rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason,
    output logic                          almost_full_out,
    output logic                          overflow_err,
    output logic [7:0]                    drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    rsp_entry_t    a_entry;
    rsp_entry_t    b_entry;
    rsp_entry_t    head;
    rsp_entry_t    rsp_q;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic [1:0]    drop;
    logic [1:0]    drop_inc;
    logic          pop;

    assign a_entry = {a_id, a_page_idx, a_fail, a_fail_reason};
    assign b_entry = {b_id, b_page_idx, b_fail, b_fail_reason};

    // B goes to the priority port so it is drained first and survives overflow.
    rsp_stage_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RSP_ENTRY_WIDTH)
    ) u_stage_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (b_wr_en),
        .wr0_data (b_entry),
        .wr1_en   (a_wr_en),
        .wr1_data (a_entry),
        .rd_en    (pop),
        .count    (count),
        .head     (head),
        .drop     (drop)
    );

    assign pop             = (count != '0) && !rsp_fifo_full;
    assign free_slots      = CW'(DEPTH) - count;
    assign almost_full_out = (free_slots <= CW'(AF_MARGIN)) || rsp_fifo_almost_full;
    assign drop_inc        = {1'b0, drop[1]} + {1'b0, drop[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_wr_en    <= 1'b0;
            rsp_q        <= '0;
            overflow_err <= 1'b0;
            drop_count   <= '0;
        end else begin
            rsp_wr_en <= pop;
            if (pop) rsp_q <= head;
            if (drop != 2'b00) overflow_err <= 1'b1;
            drop_count <= sat_add8(drop_count, drop_inc);
        end
    end

    assign rsp_id          = rsp_q.id;
    assign rsp_page_idx    = rsp_q.page_idx;
    assign rsp_fail        = rsp_q.fail;
    assign rsp_fail_reason = rsp_q.fail_reason;

endmodule
